// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed 7-segment display driver for DIGITS BCD digits.
// A prescaler (pcnt) holds each digit for PRESCALE cycles, a digit index (idx)
// walks the digits, and a double-buffered display register (shd -> disp)
// only changes at frame boundaries, so a frame never mixes old and new values.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         scan enable; low = display dark, scan position frozen
//   load       one-cycle strobe: capture bcd_in
//   bcd_in     packed BCD, bits [3:0] = digit 0 (least significant)
//   seg        segments a..g, active-high, seg[0]=a .. seg[6]=g (registered)
//   dig        one-hot digit select, dig[i] selects digit i (registered)
//   frame_done one-cycle pulse, coincident with dig returning to digit 0
//   pending    a loaded value is waiting for the next frame boundary
//
// Build option:
//   LEADING_ZERO_BLANK_EN  blank zero digits above the most significant
//                          non-zero digit (digit 0 is never blanked).
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [0:6]            seg,
    output logic [0:DIGITS-1]     dig,
    output logic                  frame_done,
    output logic                  pending
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

    logic [PW-1:0]         pcnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   shd;
    logic [4*DIGITS-1:0]   disp;
    logic                  tick;
    logic                  boundary;
    logic                  bnd_q;     // boundary seen, waiting for the output stage
    logic [0:DIGITS-1]     dig_next;
    logic [3:0]            cur_digit;
    logic                  cur_blank;

    function automatic logic [0:6] decode7(input logic [3:0] b);
        case (b)
            4'd0:    decode7 = 7'b1111110;
            4'd1:    decode7 = 7'b0110000;
            4'd2:    decode7 = 7'b1101101;
            4'd3:    decode7 = 7'b1111001;
            4'd4:    decode7 = 7'b0110011;
            4'd5:    decode7 = 7'b1011011;
            4'd6:    decode7 = 7'b1011111;
            4'd7:    decode7 = 7'b1110000;
            4'd8:    decode7 = 7'b1111111;
            4'd9:    decode7 = 7'b1111011;
            default: decode7 = 7'b0000000;   // 10..15 are shown blank
        endcase
    endfunction

    assign tick     = en && (pcnt == PCNT_MAX);
    assign boundary = tick && (idx == IDX_MAX);

    // Scan position: frozen while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (en) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values, regardless of statement order.
            if (tick) begin
                pcnt <= '0;
                idx  <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    // Double buffer. A load goes straight to disp when no frame is in
    // flight (dark) or when it lands on the boundary itself; otherwise it
    // waits in shd until the next boundary. Latest load always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the display buffers are reset like any other register so
            // a reset mid-frame discards a pending value and shows zero.
            shd     <= '0;
            disp    <= '0;
            pending <= 1'b0;
        end else if (load && (!en || boundary)) begin
            disp    <= bcd_in;
            pending <= 1'b0;
        end else if (load) begin
            shd     <= bcd_in;
            pending <= 1'b1;
        end else if (boundary && pending) begin
            disp    <= shd;
            pending <= 1'b0;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_mask;
    logic              all_zero;

    // blank_mask[i] is set when digit i and every digit above it are zero.
    // Digit 0 is left clear so a value of zero still shows one "0".
    always_comb begin
        blank_mask = '0;
        all_zero   = 1'b1;
        // NOTE: blocking assignments here are intentional: all_zero is a
        // running AND carried from one loop iteration to the next.
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero      = all_zero & (disp[4*i +: 4] == 4'd0);
            blank_mask[i] = all_zero;
        end
    end
`endif

    // Select the current digit and build its one-hot strobe.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        dig_next  = '0;
        cur_digit = '0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                dig_next[i] = 1'b1;
                cur_digit   = disp[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                cur_blank   = blank_mask[i];
`endif
            end
        end
    end

    // Registered outputs. frame_done is delayed one extra stage so it lines
    // up with the cycle where dig first shows digit 0 of the new frame; bnd_q
    // holds across a dark period so the pulse is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= '0;
            dig        <= '0;
            frame_done <= 1'b0;
            bnd_q      <= 1'b0;
        end else if (en) begin
            dig        <= dig_next;
            seg        <= cur_blank ? 7'b0000000 : decode7(cur_digit);
            frame_done <= bnd_q;
            bnd_q      <= boundary;
        end else begin
            dig        <= '0;
            seg        <= '0;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Directed bench for seg_scan_driver with DIGITS=4, PRESCALE=4. Inputs are
// driven right after the falling edge; outputs are sampled on the falling
// edge. k counts rising edges taken with en=1 since the last reset release;
// the output after edge k shows digit ((k-1)/4)%4.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en     = 1'b0;
    logic        load   = 1'b0;
    logic [15:0] bcd_in = 16'h0;
    logic [0:6]  seg;
    logic [0:3]  dig;
    logic        frame_done;
    logic        pending;

    int passed = 0;
    int total  = 0;
    int k      = 0;

    seg_scan_driver #(.DIGITS(4), .PRESCALE(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .bcd_in     (bcd_in),
        .seg        (seg),
        .dig        (dig),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [0:6] pat(input logic [3:0] n);
        case (n)
            4'd0:    pat = 7'b1111110;
            4'd1:    pat = 7'b0110000;
            4'd2:    pat = 7'b1101101;
            4'd3:    pat = 7'b1111001;
            4'd4:    pat = 7'b0110011;
            4'd5:    pat = 7'b1011011;
            4'd6:    pat = 7'b1011111;
            4'd7:    pat = 7'b1110000;
            4'd8:    pat = 7'b1111111;
            4'd9:    pat = 7'b1111011;
            default: pat = 7'b0000000;
        endcase
    endfunction

    function automatic logic [0:6] exp_seg(input logic [15:0] v, input int d);
        logic [15:0] upper;
        upper = v >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && upper == 16'h0) return 7'b0000000;
`endif
        return pat(upper[3:0]);
    endfunction

    function automatic logic [0:3] onehot(input int d);
        logic [0:3] r;
        r = 4'b1000 >> d;
        return r;
    endfunction

    function automatic int digit_of(input int kk);
        return ((kk - 1) / 4) % 4;
    endfunction

    // One clock: rising edge, then falling edge where outputs are sampled.
    task automatic cycle();
        logic en_s;
        @(posedge clk);
        en_s = en;
        @(negedge clk);
        if (en_s) k++;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        en     = 1'b0;
        load   = 1'b0;
        bcd_in = 16'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k     = 0;
    endtask

    // Load a value while dark; it reaches disp on the next edge.
    task automatic load_dark(input logic [15:0] v);
        load   = 1'b1;
        bcd_in = v;
        cycle();
        load   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        total++; if (dig !== 4'b0000) $display("FAIL reset_dig got %b want 0000", dig); else passed++;
        total++; if (seg !== 7'b0) $display("FAIL reset_seg got %b want 0000000", seg); else passed++;
        total++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else passed++;
        total++; if (pending !== 1'b0) $display("FAIL reset_pending got %b want 0", pending); else passed++;
    endtask

    // Free scan of value 0: dig walks digits, frame_done every 16 cycles.
    task automatic test_scan();
        logic fd_exp;
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 33; c++) begin
            cycle();
            fd_exp = (k > 1) && ((k - 1) % 16 == 0);
            total++; if (dig !== onehot(digit_of(k))) $display("FAIL scan_dig k=%0d got %b want %b", k, dig, onehot(digit_of(k))); else passed++;
            total++; if (seg !== exp_seg(16'h0000, digit_of(k))) $display("FAIL scan_seg k=%0d got %b want %b", k, seg, exp_seg(16'h0000, digit_of(k))); else passed++;
            total++; if (frame_done !== fd_exp) $display("FAIL scan_frame_done k=%0d got %b want %b", k, frame_done, fd_exp); else passed++;
        end
    endtask

    // Load while dark goes straight to disp; outputs stay dark.
    task automatic test_load_dark();
        do_reset();
        load_dark(16'h1234);
        total++; if (pending !== 1'b0) $display("FAIL dark_pending got %b want 0", pending); else passed++;
        total++; if (dig !== 4'b0000) $display("FAIL dark_dig got %b want 0000", dig); else passed++;
        total++; if (seg !== 7'b0) $display("FAIL dark_seg got %b want 0000000", seg); else passed++;
        en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            cycle();
            total++; if (dig !== onehot(digit_of(k))) $display("FAIL dark_scan_dig k=%0d got %b want %b", k, dig, onehot(digit_of(k))); else passed++;
            total++; if (seg !== exp_seg(16'h1234, digit_of(k))) $display("FAIL dark_scan_seg k=%0d got %b want %b", k, seg, exp_seg(16'h1234, digit_of(k))); else passed++;
        end
    endtask

    // Mid-frame load waits for the boundary.
    task automatic test_pending();
        logic [15:0] shown;
        do_reset();
        load_dark(16'h1234);
        en = 1'b1;
        while (k < 5) cycle();
        load   = 1'b1;
        bcd_in = 16'h5678;
        cycle();                               // edge k=6: idx=1, pcnt=1
        load   = 1'b0;
        total++; if (pending !== 1'b1) $display("FAIL pend_set got %b want 1", pending); else passed++;
        while (k < 32) begin
            cycle();
            shown = (k <= 16) ? 16'h1234 : 16'h5678;
            total++; if (seg !== exp_seg(shown, digit_of(k))) $display("FAIL pend_seg k=%0d got %b want %b", k, seg, exp_seg(shown, digit_of(k))); else passed++;
            if (k == 16) begin
                total++; if (pending !== 1'b0) $display("FAIL pend_clear got %b want 0", pending); else passed++;
            end
            if (k == 17) begin
                total++; if (frame_done !== 1'b1) $display("FAIL pend_frame_done got %b want 1", frame_done); else passed++;
            end
        end
    endtask

    // Two loads in one frame, then a load on the boundary edge itself.
    task automatic test_back_to_back();
        logic [15:0] shown;
        do_reset();
        en = 1'b1;
        while (k < 48) begin
            load = 1'b1;
            case (k + 1)
                3:       bcd_in = 16'h1111;
                7:       bcd_in = 16'h9999;
                32:      bcd_in = 16'h2468;   // boundary edge: idx=3, pcnt=3
                default: load = 1'b0;
            endcase
            cycle();
            load = 1'b0;
            if (k == 3 || k == 7) begin
                total++; if (pending !== 1'b1) $display("FAIL b2b_pending_set k=%0d got %b want 1", k, pending); else passed++;
            end
            if (k == 16 || k == 32) begin
                total++; if (pending !== 1'b0) $display("FAIL b2b_pending_clear k=%0d got %b want 0", k, pending); else passed++;
            end
            shown = (k <= 16) ? 16'h0000 : (k <= 32) ? 16'h9999 : 16'h2468;
            total++; if (seg !== exp_seg(shown, digit_of(k))) $display("FAIL b2b_seg k=%0d got %b want %b", k, seg, exp_seg(shown, digit_of(k))); else passed++;
        end
    endtask

    // Codes >= 10 blank; leading zeros depend on the build option.
    task automatic test_blank();
        do_reset();
        load_dark(16'h00A0);
        en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            cycle();
            total++; if (seg !== exp_seg(16'h00A0, digit_of(k))) $display("FAIL blank_seg k=%0d got %b want %b", k, seg, exp_seg(16'h00A0, digit_of(k))); else passed++;
        end
    endtask

    // en low mid-slot freezes the position; re-enable resumes there.
    task automatic test_freeze();
        do_reset();
        load_dark(16'h1234);
        en = 1'b1;
        while (k < 6) cycle();
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            total++; if (dig !== 4'b0000) $display("FAIL freeze_dig got %b want 0000", dig); else passed++;
            total++; if (seg !== 7'b0) $display("FAIL freeze_seg got %b want 0000000", seg); else passed++;
        end
        en = 1'b1;
        while (k < 17) begin
            cycle();
            total++; if (dig !== onehot(digit_of(k))) $display("FAIL resume_dig k=%0d got %b want %b", k, dig, onehot(digit_of(k))); else passed++;
            total++; if (seg !== exp_seg(16'h1234, digit_of(k))) $display("FAIL resume_seg k=%0d got %b want %b", k, seg, exp_seg(16'h1234, digit_of(k))); else passed++;
        end
        total++; if (frame_done !== 1'b1) $display("FAIL resume_frame_done got %b want 1", frame_done); else passed++;
    endtask

    // Reset mid-frame with a pending value: everything clears, value lost.
    task automatic test_reset_mid();
        do_reset();
        load_dark(16'h1234);
        en = 1'b1;
        while (k < 8) cycle();
        load   = 1'b1;
        bcd_in = 16'h5678;
        cycle();                               // edge k=9: idx=2
        load   = 1'b0;
        total++; if (pending !== 1'b1) $display("FAIL rmid_pending got %b want 1", pending); else passed++;
        cycle();
        rst_n = 1'b0;
        #1;
        total++; if (dig !== 4'b0000) $display("FAIL rmid_dig got %b want 0000", dig); else passed++;
        total++; if (seg !== 7'b0) $display("FAIL rmid_seg got %b want 0000000", seg); else passed++;
        total++; if (pending !== 1'b0) $display("FAIL rmid_pending_clr got %b want 0", pending); else passed++;
        total++; if (frame_done !== 1'b0) $display("FAIL rmid_frame_done got %b want 0", frame_done); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        k     = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            total++; if (dig !== onehot(digit_of(k))) $display("FAIL rmid_scan_dig k=%0d got %b want %b", k, dig, onehot(digit_of(k))); else passed++;
            total++; if (seg !== exp_seg(16'h0000, digit_of(k))) $display("FAIL rmid_scan_seg k=%0d got %b want %b", k, seg, exp_seg(16'h0000, digit_of(k))); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_dark();
        test_pending();
        test_back_to_back();
        test_blank();
        test_freeze();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
